// File: rtl/dco_fll_ctrl.sv
// dco_fll_ctrl: SAR-then-track frequency-locking loop for an 8-bit DCO
//   clk      system clock            rst_n   async active-low reset
//   ena      enable, low forces IDLE start   one-cycle acquisition request
//   target   wanted DCO edges/window  dco_clk raw DCO output (async)
//   dco_code DCO control code        meas    edge count of last window
//   busy     not IDLE                locked  frequency lock indicator
module dco_fll_ctrl #(
  parameter int WIN_CYCLES = 256,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W = 12,
  parameter int TOL = 1,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [CNT_W-1:0] target,
  input  logic             dco_clk,
  output logic [7:0]       dco_code,
  output logic [CNT_W-1:0] meas,
  output logic             busy,
  output logic             locked
);
  localparam int TMAX = WIN_CYCLES > SETTLE_CYC ? WIN_CYCLES : SETTLE_CYC;
  localparam int TW = $clog2(TMAX + 1);
  localparam int LW = $clog2(LOCK_N + 1);
  localparam logic [TW-1:0] WIN_LAST = TW'(WIN_CYCLES - 1);
  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_N);
  localparam logic [CNT_W:0] TOL_X = (CNT_W + 1)'(TOL);
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DECIDE} state_t;
  state_t state, state_nxt;
  logic s1, s2, s3, rise, tmr_done, hi, lo, phase;
  logic [TW-1:0] tmr;
  logic [CNT_W-1:0] cnt, cnt_inc, tgt;
  logic [2:0] bit_idx;
  logic [LW-1:0] lock_cnt;
  logic [7:0] sar_code;
  assign busy = state != IDLE;
  assign rise = s2 & ~s3;
  assign tmr_done = tmr == (state == SETTLE ? SET_LAST : WIN_LAST);
  // saturating increment; also feeds meas so an edge in the last window cycle counts
  assign cnt_inc = (rise && !(&cnt)) ? cnt + 1'b1 : cnt;
  // one extra bit so target+TOL and meas+TOL cannot wrap
  assign hi = {1'b0, meas} > {1'b0, tgt} + TOL_X;
  assign lo = {1'b0, meas} + TOL_X < {1'b0, tgt};
  always_comb begin
    sar_code = dco_code;
    if (meas > tgt) sar_code[bit_idx] = 1'b0;
    if (bit_idx != 3'd0) sar_code[bit_idx - 3'd1] = 1'b1;
  end
  always_comb begin
    state_nxt = state;
    state_nxt = !ena ? IDLE :
                state == IDLE ? (start ? SETTLE : IDLE) :
                state == SETTLE ? (tmr_done ? MEASURE : SETTLE) :
                state == MEASURE ? (tmr_done ? DECIDE : MEASURE) : SETTLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {dco_clk, s1, s2};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
      cnt <= '0;
      meas <= '0;
      tgt <= '0;
      dco_code <= 8'h80;
      bit_idx <= 3'd7;
      phase <= 1'b0;
      lock_cnt <= '0;
      locked <= 1'b0;
    end else begin
      tmr <= (ena && (state == SETTLE || state == MEASURE) && !tmr_done) ? tmr + 1'b1 : '0;
      if (!ena) begin
        cnt <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            tgt <= target;
            dco_code <= 8'h80;
            bit_idx <= 3'd7;
            phase <= 1'b0;
            lock_cnt <= '0;
            locked <= 1'b0;
          end
          SETTLE: if (tmr_done) cnt <= '0;
          MEASURE: begin
            cnt <= cnt_inc;
            if (tmr_done) meas <= cnt_inc;
          end
          DECIDE: if (!phase) begin
            dco_code <= sar_code;
            if (bit_idx != 3'd0) bit_idx <= bit_idx - 3'd1;
            else phase <= 1'b1;
          end else if (hi) begin
            dco_code <= dco_code - {7'd0, |dco_code};
            lock_cnt <= '0;
            locked <= 1'b0;
          end else if (lo) begin
            dco_code <= dco_code + {7'd0, ~&dco_code};
            lock_cnt <= '0;
            locked <= 1'b0;
          end else begin
            if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 1'b1;
            locked <= lock_cnt >= LOCK_MAX - LW'(1);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dco_fll_ctrl.sv
// tb_dco_fll_ctrl: scoreboard bench for dco_fll_ctrl with an exact-rate DCO model
`timescale 1ns/1ps
module tb_dco_fll_ctrl;
  localparam int STEP = 273;
  logic clk = 0, rst_n = 0, ena = 0, start = 0, dco_clk;
  logic [11:0] target = 0;
  logic [7:0] dco_code;
  logic [11:0] meas;
  logic busy, locked;
  logic rst2_n = 0, start2 = 0, dco2 = 0;
  logic [7:0] code2;
  logic [11:0] meas2;
  logic busy2, locked2;
  always #5 clk = ~clk;
  dco_fll_ctrl u_dut (.clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .target(target),
    .dco_clk(dco_clk), .dco_code(dco_code), .meas(meas), .busy(busy), .locked(locked));
  dco_fll_ctrl #(.WIN_CYCLES(8320)) u_sat (.clk(clk), .rst_n(rst2_n), .ena(1'b1), .start(start2),
    .target(12'd100), .dco_clk(dco2), .dco_code(code2), .meas(meas2), .busy(busy2), .locked(locked2));
  int off = 0, acc = 0;
  bit sq_mode = 0;
  logic pulse = 0, sq = 0;
  // code/2+off rising edges per 256 clocks, periodic so any 256-cycle span holds exactly that many
  always @(negedge clk) begin : mdl
    int n, a;
    n = int'(dco_code) / 2 + off;
    n = n < 0 ? 0 : n > 127 ? 127 : n;
    a = acc + n;
    acc <= a >= 256 ? a - 256 : a;
    pulse <= a >= 256;
    dco2 <= ~dco2;
  end
  initial begin
    #3.7;
    forever #32 sq = ~sq;
  end
  assign dco_clk = sq_mode ? sq : pulse;
  typedef struct {
    string name;
    int step, code_lo, code_hi, lck, bsy, ms_lo, ms_hi;
    bit sat;
  } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, cyc = -1, step_cnt = 0;
  function automatic void push(string n, int st, int clo, int chi, int lck, int bsy, int mlo, int mhi, bit sat = 0);
    exp_t e;
    e.name = n; e.step = st; e.code_lo = clo; e.code_hi = chi; e.lck = lck;
    e.bsy = bsy; e.ms_lo = mlo; e.ms_hi = mhi; e.sat = sat;
    sb.push_back(e);
  endfunction
  task automatic cmp(string n, int act, int lo, int hi);
    if (lo < 0) return;
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d..%0d", n, act, lo, hi);
    end
  endtask
  always @(negedge clk) begin : mon
    bit bound;
    exp_t e;
    cyc = busy ? cyc + 1 : -1;
    bound = busy && cyc > 0 && cyc % STEP == 0;
    if (bound) step_cnt = cyc / STEP;
    if (!busy) step_cnt = 0;
    while (sb.size() > 0 && (sb[0].step < 0 || (bound && sb[0].step <= step_cnt))) begin
      e = sb.pop_front();
      if (e.step >= 0) cmp({e.name, "_step"}, step_cnt, e.step, e.step);
      if (e.sat) cmp({e.name, "_meas"}, int'(meas2), e.ms_lo, e.ms_hi);
      else begin
        cmp({e.name, "_code"}, int'(dco_code), e.code_lo, e.code_hi);
        cmp({e.name, "_locked"}, int'(locked), e.lck, e.lck);
        cmp({e.name, "_busy"}, int'(busy), e.bsy, e.bsy);
        cmp({e.name, "_meas"}, int'(meas), e.ms_lo, e.ms_hi);
      end
    end
  end
  task automatic wait_step(int k);
    int n = 0;
    while (step_cnt < k && n < (k + 2) * STEP) begin
      @(posedge clk);
      n++;
    end
    cmp("step_timeout", step_cnt, k, 1 << 30);
    #1;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 2 * STEP) begin
      @(posedge clk);
      n++;
    end
    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s: expectation never reached, step now %0d want %0d", sb[0].name, step_cnt, sb[0].step);
      void'(sb.pop_front());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic go(int t);
    @(posedge clk);
    #1 target = 12'(t); start = 1;
    @(posedge clk);
    #1 start = 0;
    push("start", -1, 'h80, 'h80, 0, 1, -1, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1; rst2_n = 1; ena = 1;
    push("reset", -1, 'h80, 'h80, 0, 0, 0, 0);
    drain();
    start2 = 1;
    @(posedge clk);
    #1 start2 = 0;
    go(30);
    push("r_s5", 5, 'h3C, 'h3C, 0, 1, 28, 28);
    wait_step(5);
    drain();
    repeat (100) @(posedge clk);
    #1 rst_n = 0;
    push("async_reset", -1, 'h80, 'h80, 0, 0, 0, 0);
    drain();
    rst_n = 1;
    repeat (20) @(posedge clk);
    push("idle_after_rst", -1, 'h80, 'h80, 0, 0, 0, 0);
    drain();
    go(100);
    push("sar1", 1, 'hC0, 'hC0, 0, 1, 64, 64);
    push("sar2", 2, 'hE0, 'hE0, 0, 1, 96, 96);
    push("sar3", 3, 'hD0, 'hD0, 0, 1, 112, 112);
    push("sar4", 4, 'hC8, 'hC8, 0, 1, 104, 104);
    push("sar5", 5, 'hCC, 'hCC, 0, 1, 100, 100);
    push("sar6", 6, 'hCA, 'hCA, 0, 1, 102, 102);
    push("sar7", 7, 'hC9, 'hC9, 0, 1, 101, 101);
    push("sar8", 8, 'hC8, 'hC9, 0, 1, 100, 100);
    push("pre_lock", 11, 'hC9, 'hC9, 0, 1, 100, 100);
    push("lock", 12, 'hC9, 'hC9, 1, 1, 100, 100);
    wait_step(1);
    repeat (50) @(posedge clk);
    #1 target = 5; start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_step(12);
    off = -10;
    push("slow13", 13, 'hCA, 'hCA, 0, 1, 90, 90);
    push("slow20", 20, 'hD1, 'hD1, 0, 1, -1, 0);
    push("slow29", 29, 'hDA, 'hDA, 0, 1, -1, 0);
    push("slow32", 32, 'hDA, 'hDA, 0, 1, 99, 99);
    push("slow_lock", 33, 'hDA, 'hDA, 1, 1, 99, 99);
    wait_step(33);
    off = 10;
    push("fast34", 34, 'hD9, 'hD9, 0, 1, 119, 119);
    push("fast50", 50, 'hC9, 'hC9, 0, 1, -1, 0);
    push("fast68", 68, 'hB7, 'hB7, 0, 1, -1, 0);
    push("fast71", 71, 'hB7, 'hB7, 0, 1, 101, 101);
    push("fast_lock", 72, 'hB7, 'hB7, 1, 1, 101, 101);
    wait_step(72);
    drain();
    ena = 0;
    @(posedge clk);
    #1 push("ena_low_locked", -1, 'hB7, 'hB7, 0, 0, 101, 101);
    drain();
    off = 0; ena = 1;
    go(100);
    push("sar3b", 3, 'hD0, 'hD0, 0, 1, 112, 112);
    wait_step(3);
    drain();
    repeat (50) @(posedge clk);
    #1 ena = 0;
    @(posedge clk);
    #1 push("ena_low_sar", -1, 'hD0, 'hD0, 0, 0, 112, 112);
    drain();
    ena = 1;
    go(4095);
    push("top_sar", 8, 'hFF, 'hFF, 0, 1, -1, 0);
    push("top_hold", 10, 'hFF, 'hFF, 0, 1, 127, 127);
    wait_step(10);
    drain();
    ena = 0;
    @(posedge clk);
    #1 ena = 1; off = 10;
    go(0);
    push("bot_sar", 8, 'h00, 'h00, 0, 1, -1, 0);
    push("bot_hold", 10, 'h00, 'h00, 0, 1, 10, 10);
    wait_step(10);
    drain();
    ena = 0;
    @(posedge clk);
    #1 ena = 1; off = 0; sq_mode = 1;
    go(40);
    for (int i = 1; i <= 6; i++) push($sformatf("sq_win%0d", i), i, -1, 0, -1, 1, 39, 41);
    wait_step(6);
    drain();
    ena = 0;
    push("meas_sat", -1, -1, 0, -1, -1, 4095, 4095, 1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dco_fll_ctrl.md
# dco_fll_ctrl

Frequency-locking controller for the 8-bit digitally controlled oscillator. It drives the DCO control code and counts DCO rising edges over a fixed window of system clocks. A binary (SAR) search, followed by ±1 tracking, brings the measured count to a programmed target. It sits between the top-level `ui_in` configuration path and the DCO code input, replacing the static code.

## Interface

Parameters:

- `WIN_CYCLES`, 256: measurement window length in `clk` cycles.
- `SETTLE_CYC`, 16: wait after every code change before measuring, in `clk` cycles.
- `CNT_W`, 12: width of the edge counter, `target` and `meas`.
- `TOL`, 1: lock tolerance in counts, unsigned.
- `LOCK_N`, 4: consecutive in-tolerance tracking windows required to assert `locked`.

Ports (one clock; reset is asynchronous and active-low):

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `ena`  in  1  block enable; low forces IDLE
- `start`  in  1  single-cycle request to begin acquisition
- `target`  in  CNT_W  desired DCO rising edges per window; sampled on accepted `start`
- `dco_clk`  in  1  raw DCO output, asynchronous to `clk`
- `dco_code`  out  8  DCO control code
- `meas`  out  CNT_W  edge count from the last completed window
- `busy`  out  1  high in every state except IDLE
- `locked`  out  1  frequency lock indicator

## Operation

- Edge detection:
  - `dco_clk` passes through a 2-flop synchronizer, then a third flop.
  - A rising edge is `s2 & ~s3`.
  - The edge counter increments only in MEASURE and saturates at all-ones.
  - DCO frequency must stay below `clk`/2. Counts above that are undefined but must not wrap.
- States: IDLE, SETTLE, MEASURE, DECIDE.
  - The `phase` flag selects SAR or TRACK behaviour in DECIDE.
- IDLE:
  - Waits for `start & ena`.
  - On accept: latch `target`, `dco_code`=0x80, `bit_idx`=7, `phase`=SAR, clear the lock counter and `locked`, go to SETTLE.
- SETTLE:
  - Counts `SETTLE_CYC` cycles.
  - On the last cycle: clear the edge counter, go to MEASURE.
- MEASURE:
  - Counts `WIN_CYCLES` cycles with edge counting enabled.
  - On the last cycle: register the final count (including an edge detected in that cycle) into `meas`, go to DECIDE.
- DECIDE (1 cycle). Code is monotonic: a higher code gives a higher frequency.
  - SAR phase:
    - If `meas` > `target`, clear `dco_code[bit_idx]`.
    - If `bit_idx` > 0: set `dco_code[bit_idx-1]`, decrement `bit_idx`.
    - Otherwise set `phase`=TRACK.
    - Go to SETTLE.
  - TRACK phase: compare in CNT_W+1 bits, so there is no wrap.
    - If `meas` > `target`+`TOL`: `dco_code`−1, saturating at 0x00. Clear the lock counter and `locked`.
    - Else if `meas`+`TOL` < `target`: `dco_code`+1, saturating at 0xFF. Clear the lock counter and `locked`.
    - Else: increment the lock counter, saturating at `LOCK_N`. `locked`=1 once it reaches `LOCK_N`.
    - Go to SETTLE.
- Tracking runs indefinitely until `ena` falls.
- `start` is ignored while `busy`=1.
- `target` changes while busy have no effect until the next accepted `start`.
- `ena` low in any state:
  - Next state is IDLE.
  - `locked` clears and the edge counter clears.
  - `dco_code` and `meas` hold their values.
- Reset, asynchronous at any time, including mid-window:
  - `dco_code`=0x80, `meas`=0, `busy`=0, `locked`=0.
  - State IDLE, synchronizer flops 0, all counters 0.

## Timing

- `start` sampled high at edge N gives `busy`=1 and `dco_code`=0x80 from edge N, so both are visible after edge N.
- One step (window) is `SETTLE_CYC` + `WIN_CYCLES` + 1 cycles; with defaults, 273.
- `dco_code` updates in the cycle after DECIDE, i.e. registered on the DECIDE edge.
- `meas` updates on the transition MEASURE→DECIDE.
- SAR completes after 8 steps (2184 cycles with defaults), then tracking begins.
- Earliest `locked` assertion: 8 + `LOCK_N` steps after `start` (3276 cycles with defaults).
- `locked` asserts at the DECIDE edge and deasserts at the first out-of-tolerance DECIDE edge.
- Synchronizer latency (2 cycles) is not compensated. Edges arriving in the last 2 cycles of a window count toward the next window only if that window is in MEASURE; otherwise they are discarded.

## Test plan

- Reset: assert `rst_n`=0 mid-MEASURE with `dco_code`=0x3C.
  - Required: `dco_code`=0x80, `busy`=0, `locked`=0, `meas`=0 immediately.
  - Required: stays in IDLE after release.
- SAR convergence: bench DCO model emits `code`/2 rising edges per 256-cycle window; `target`=100; pulse `start`.
  - Required: after 8 steps, `dco_code` ∈ {0xC8, 0xC9}.
  - Required: `locked`=1 exactly `LOCK_N` steps later, at cycle 3276 ±1.
- Tracking and loss of lock:
  - After lock, change the model to `code`/2 − 10 edges. Required: `locked` drops at the next DECIDE; `dco_code` steps +1 per window until `meas` is within ±1 of 100; `locked` reasserts after 4 good windows.
  - Repeat with the model changed to `code`/2 + 10. Required: `dco_code` steps −1 per window instead.
- Saturation, both ends:
  - `target`=4095 with the model at its maximum: required `dco_code`=0xFF held, no wrap.
  - `target`=0: required `dco_code`=0x00 held.
  - `meas` saturates at 4095 when edges exceed the counter.
- Control edge cases:
  - `start` pulsed while `busy` is ignored; `target` unchanged.
  - `ena`=0 mid-SAR: IDLE next cycle, `locked`=0, `dco_code` held.
  - `ena`=1 plus `start` restarts at 0x80.
- Counting accuracy: a `dco_clk` square wave of exactly 40 rising edges within the window, asynchronous phase, gives `meas` ∈ {39, 40, 41} for every window.
